// File: rtl/dot_pkg.sv
// Shared types and defaults for the dot-product sequencer.
package dot_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int DRAIN_CYC_DEF = 2;
endpackage

// File: rtl/dot_seq.sv
// Sequences operand pairs into an external multiply-accumulate unit and
// captures the accumulated dot product once the MAC pipeline has drained.
module dot_seq
    import dot_pkg::*;
#(
    parameter int LEN_W     = 8,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             op_vld,
    input  logic [15:0]      op_A,
    input  logic [15:0]      op_B,
    output logic             op_rdy,
    output logic             mac_clr,
    output logic             mac_en,
    output logic [15:0]      mac_A,
    output logic [15:0]      mac_B,
    input  logic [63:0]      mac_accum,
    output logic [63:0]      res,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic             busy
);
    localparam int WAIT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DRAIN_CYC - 1);

    state_t            state;
    logic [LEN_W-1:0]  cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [63:0]       res_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            wait_cnt <= '0;
            res_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt   <= len;
                        state <= S_CLR;
                    end
                end
                S_CLR: begin
                    wait_cnt <= '0;
                    state    <= (cnt == '0) ? S_DRAIN : S_FEED;
                end
                S_FEED: begin
                    if (op_vld) begin
                        cnt <= cnt - 1'b1;
                        if (cnt == LEN_W'(1)) begin
                            wait_cnt <= '0;
                            state    <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // The MAC needs DRAIN_CYC cycles after its last enable to settle.
                    if (wait_cnt == WAIT_LAST) begin
                        res_q    <= mac_accum;
                        wait_cnt <= '0;
                        state    <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_rdy) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs are gated by rst so they read zero for the whole reset window.
    logic run;
    assign run     = !rst;
    assign op_rdy  = run && (state == S_FEED);
    assign mac_en  = op_rdy && op_vld;
    assign mac_clr = run && (state == S_CLR);
    assign mac_A   = op_rdy ? op_A : 16'd0;
    assign mac_B   = op_rdy ? op_B : 16'd0;
    assign res_vld = run && (state == S_DONE);
    assign busy    = run && (state != S_IDLE);
    assign res     = run ? res_q : 64'd0;
endmodule

// File: tb/tb_dot_seq.sv
// Bench for dot_seq: a two-stage MAC partner, directed jobs, and a result scoreboard.
module tb_dot_seq;
    import dot_pkg::*;

    localparam int LEN_W = 8;
    localparam int DRAIN_CYC = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             op_vld;
    logic [15:0]      op_A, op_B;
    logic             op_rdy, mac_clr, mac_en;
    logic [15:0]      mac_A, mac_B;
    logic [63:0]      mac_accum;
    logic [63:0]      res;
    logic             res_vld, res_rdy, busy;

    dot_seq #(.LEN_W(LEN_W), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .op_vld(op_vld), .op_A(op_A), .op_B(op_B), .op_rdy(op_rdy),
        .mac_clr(mac_clr), .mac_en(mac_en), .mac_A(mac_A), .mac_B(mac_B),
        .mac_accum(mac_accum), .res(res), .res_vld(res_vld),
        .res_rdy(res_rdy), .busy(busy)
    );

    always #5 clk = ~clk;

    // MAC partner: product register, then accumulate; sum settles two cycles after mac_en.
    logic [63:0] prod;
    logic        prod_v;
    always_ff @(posedge clk) begin
        if (rst) begin
            mac_accum <= '0;
            prod      <= '0;
            prod_v    <= 1'b0;
        end else if (mac_clr) begin
            mac_accum <= '0;
            prod_v    <= 1'b0;
        end else begin
            prod   <= 64'(mac_A) * 64'(mac_B);
            prod_v <= mac_en;
            if (prod_v) mac_accum <= mac_accum + prod;
        end
    end

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: event counters and scoreboard compare on each rising res_vld.
    logic [63:0] sb[$];
    int cyc = 0, last_en_cyc = 0, lat = 0;
    int en_cnt = 0, clr_cnt = 0, rdy_cnt = 0;
    logic res_vld_d = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mac_en) begin en_cnt++; last_en_cyc = cyc; end
        if (mac_clr) clr_cnt++;
        if (op_rdy) rdy_cnt++;
        if (res_vld && !res_vld_d) begin
            lat = cyc - last_en_cyc;
            if (sb.size() == 0) chk("unexpected_result", res, 64'hx);
            else chk("result", res, sb.pop_front());
        end
        res_vld_d = res_vld;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start(input logic [LEN_W-1:0] n);
        start = 1'b1; len = n;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [15:0] a, input logic [15:0] b);
        bit ok = 0;
        op_vld = 1'b1; op_A = a; op_B = b;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (op_rdy) begin ok = 1; break; end
        end
        if (!ok) chk("feed_timeout", 0, 1);
        tick();
        op_vld = 1'b0; op_A = '0; op_B = '0;
    endtask

    task automatic wait_res();
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_vld) begin ok = 1; break; end
        end
        if (!ok) chk("res_timeout", 0, 1);
        tick();
    endtask

    task automatic clr_counts();
        en_cnt = 0; clr_cnt = 0; rdy_cnt = 0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; op_vld = 1'b0;
        op_A = '0; op_B = '0; res_rdy = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("reset_ctrl", 64'({op_rdy, mac_clr, mac_en, res_vld, busy}), 64'd0);
        chk("reset_res", res, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // len=3 back-to-back: 2*3+4*5+6*7 = 68
        clr_counts();
        sb.push_back(64'd68);
        do_start(8'd3);
        feed(16'd2, 16'd3); feed(16'd4, 16'd5); feed(16'd6, 16'd7);
        wait_res();
        chk("j1_clr_pulses", 64'(clr_cnt), 64'd1);
        chk("j1_en_pulses", 64'(en_cnt), 64'd3);
        chk("j1_latency", 64'(lat), 64'd3);

        // len=2 with two bubble cycles: 0xFFFF^2 + 1 = 0xFFFE0002
        clr_counts();
        sb.push_back(64'hFFFE0002);
        do_start(8'd2);
        feed(16'hFFFF, 16'hFFFF);
        tick(); tick();
        feed(16'd1, 16'd1);
        wait_res();
        chk("j2_en_pulses", 64'(en_cnt), 64'd2);

        // len=0: no operand phase, accumulator cleared
        clr_counts();
        sb.push_back(64'd0);
        do_start(8'd0);
        wait_res();
        chk("j3_no_rdy", 64'(rdy_cnt), 64'd0);
        chk("j3_no_en", 64'(en_cnt), 64'd0);

        // res_rdy held low in DONE with a start pulse: 5*6 = 30
        res_rdy = 1'b0;
        clr_counts();
        sb.push_back(64'd30);
        do_start(8'd1);
        feed(16'd5, 16'd6);
        wait_res();
        for (int i = 0; i < 5; i++) begin
            start = (i == 1); len = 8'd7;
            @(negedge clk);
            chk("hold_res", res, 64'd30);
            chk("hold_vld", 64'(res_vld), 64'd1);
            tick();
        end
        start = 1'b0;
        res_rdy = 1'b1;
        tick();
        @(negedge clk);
        chk("after_ack_busy", 64'(busy), 64'd0);
        chk("after_ack_res", res, 64'd30);
        chk("no_restart_clr", 64'(clr_cnt), 64'd1);
        tick();

        // reset mid-FEED after one of four pairs; no result from the aborted job
        do_start(8'd4);
        feed(16'd1, 16'd2);
        op_vld = 1'b1; op_A = 16'd7; op_B = 16'd7;
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("midrst_ctrl", 64'({op_rdy, mac_clr, mac_en, res_vld, busy}), 64'd0);
        chk("midrst_data", {16'd0, mac_A, mac_B, 16'd0} | res, 64'd0);
        tick();
        rst = 1'b0; op_vld = 1'b0; op_A = '0; op_B = '0;
        tick();
        sb.push_back(64'd9);
        do_start(8'd1);
        feed(16'd3, 16'd3);
        wait_res();

        // back-to-back jobs: (1,1)x2 then (10,10)x1
        sb.push_back(64'd2);
        do_start(8'd2);
        feed(16'd1, 16'd1); feed(16'd1, 16'd1);
        wait_res();
        sb.push_back(64'd100);
        do_start(8'd1);
        feed(16'd10, 16'd10);
        wait_res();

        tick(); tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
